// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/breakpoint sequencer gating commits of the single-cycle MIPS core
module cpu_run_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          RESET_HOLD      = 4,
  parameter logic [31:0] HALT_INST       = 32'h0000000C
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        run_req,
  input  logic        step_btn,
  input  logic        bp_enable,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  output logic        cpu_reset,
  output logic        cpu_en,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] retired
);
  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_HALT  = 3'd1,
    S_STEP  = 3'd2,
    S_RUN   = 3'd3,
    S_BREAK = 3'd4
  } state_t;
  state_t st, st_nx;
  logic s1, s2, stable, stable_d, step_pulse, bp_hit, halt_hit;
  logic [15:0] cnt;
  logic [7:0] hold;
  assign step_pulse = stable & ~stable_d;
  assign bp_hit = bp_enable & (pc == bp_addr);
  assign halt_hit = inst == HALT_INST;
  assign cpu_en = (st == S_RUN & run_req & ~bp_hit & ~halt_hit) | (st == S_STEP & ~halt_hit);
  assign cpu_reset = st == S_INIT;
  assign halted = st == S_HALT | st == S_BREAK;
  assign state = st;
  // synchronise the button, accept a level only after it holds DEBOUNCE_CYCLES cycles
  always_ff @(posedge clock_in) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      stable <= 1'b0;
      stable_d <= 1'b0;
      cnt <= 16'd0;
    end else begin
      s1 <= step_btn;
      s2 <= s1;
      stable_d <= stable;
      if (s2 == stable) cnt <= 16'd0;
      else if (cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
        stable <= s2;
        cnt <= 16'd0;
      end else cnt <= cnt + 16'd1;
    end
  end
  // state register, reset-hold countdown and retired-instruction counter
  always_ff @(posedge clock_in) begin
    if (reset) begin
      st <= S_INIT;
      hold <= 8'(RESET_HOLD);
      retired <= 32'd0;
    end else begin
      st <= st_nx;
      if (st == S_INIT) hold <= hold - 8'd1;
      retired <= (st == S_INIT) ? 32'd0 : retired + {31'd0, cpu_en};
    end
  end
  // next state; run beats step in HALT, step beats run-drop in BREAK
  always_comb begin
    st_nx = st;
    case (st)
      S_INIT:  st_nx = (hold == 8'd1) ? S_HALT : S_INIT;
      S_HALT:  st_nx = run_req ? S_RUN : step_pulse ? S_STEP : S_HALT;
      S_STEP:  st_nx = halt_hit ? S_BREAK : S_HALT;
      S_RUN:   st_nx = !run_req ? S_HALT : (bp_hit | halt_hit) ? S_BREAK : S_RUN;
      S_BREAK: st_nx = step_pulse ? S_STEP : !run_req ? S_HALT : S_BREAK;
      default: st_nx = S_INIT;
    endcase
  end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed checks of reset hold, step debounce, run, breakpoint and halt handling
module tb_cpu_run_ctrl;
  logic clock_in = 1'b0;
  logic reset = 1'b1;
  logic run_req = 1'b0;
  logic step_btn = 1'b0;
  logic bp_enable = 1'b0;
  logic [31:0] bp_addr = 32'd0;
  logic [31:0] pc = 32'd0;
  logic [31:0] inst = 32'h20080005;
  logic cpu_reset, cpu_en, halted;
  logic [2:0] state;
  logic [31:0] retired;
  int checks = 0;
  int failures = 0;
  int en_cnt = 0;
  cpu_run_ctrl #(.DEBOUNCE_CYCLES(4), .RESET_HOLD(4), .HALT_INST(32'h0000000C)) dut (
    .clock_in(clock_in), .reset(reset), .run_req(run_req), .step_btn(step_btn),
    .bp_enable(bp_enable), .bp_addr(bp_addr), .pc(pc), .inst(inst),
    .cpu_reset(cpu_reset), .cpu_en(cpu_en), .state(state), .halted(halted), .retired(retired)
  );
  always #5 clock_in = ~clock_in;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock_in);
      #1;
      en_cnt += int'(cpu_en);
    end
  endtask
  initial begin
    tick(2);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_en", 32'(cpu_en), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_retired", retired, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("hold_cpu_reset", 32'(cpu_reset), 32'd1);
      tick();
    end
    chk("init_done_state", 32'(state), 32'd1);
    chk("init_done_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("init_done_halted", 32'(halted), 32'd1);
    chk("init_done_en", 32'(cpu_en), 32'd0);
    chk("init_done_retired", retired, 32'd0);
    step_btn = 1'b1;
    en_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 6) chk("step_wait_state", 32'(state), 32'd1);
      if (i == 7) begin
        chk("step_state", 32'(state), 32'd2);
        chk("step_en", 32'(cpu_en), 32'd1);
      end
      if (i == 10) step_btn = 1'b0;
    end
    chk("step_single_en", 32'(en_cnt), 32'd1);
    chk("step_retired", retired, 32'd1);
    chk("step_back_halt", 32'(state), 32'd1);
    tick(6);
    en_cnt = 0;
    step_btn = 1'b1;
    tick(2);
    step_btn = 1'b0;
    tick();
    step_btn = 1'b1;
    tick(2);
    step_btn = 1'b0;
    tick(12);
    chk("glitch_no_en", 32'(en_cnt), 32'd0);
    chk("glitch_state", 32'(state), 32'd1);
    bp_enable = 1'b1;
    bp_addr = 32'h10;
    run_req = 1'b1;
    #1;
    chk("halt_no_en", 32'(cpu_en), 32'd0);
    tick();
    chk("run_state", 32'(state), 32'd3);
    for (int i = 0; i < 4; i++) begin
      pc = 32'(i * 4);
      #1;
      chk("run_en", 32'(cpu_en), 32'd1);
      tick();
    end
    pc = 32'h10;
    #1;
    chk("bp_no_en", 32'(cpu_en), 32'd0);
    tick();
    chk("bp_state", 32'(state), 32'd4);
    chk("bp_halted", 32'(halted), 32'd1);
    chk("bp_retired", retired, 32'd5);
    tick();
    chk("bp_run_stays_break", 32'(state), 32'd4);
    step_btn = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 6) chk("brk_wait_state", 32'(state), 32'd4);
      if (i == 7) begin
        chk("brk_step_state", 32'(state), 32'd2);
        chk("brk_step_en", 32'(cpu_en), 32'd1);
      end
    end
    tick();
    chk("brk_step_halt", 32'(state), 32'd1);
    chk("brk_step_retired", retired, 32'd6);
    pc = 32'h14;
    step_btn = 1'b0;
    tick();
    chk("resume_state", 32'(state), 32'd3);
    chk("resume_en", 32'(cpu_en), 32'd1);
    tick();
    chk("resume_retired", retired, 32'd7);
    inst = 32'h0000000C;
    #1;
    chk("hi_no_en", 32'(cpu_en), 32'd0);
    tick();
    chk("hi_state", 32'(state), 32'd4);
    tick(6);
    step_btn = 1'b1;
    tick(7);
    chk("hi_step_state", 32'(state), 32'd2);
    chk("hi_step_no_en", 32'(cpu_en), 32'd0);
    step_btn = 1'b0;
    tick();
    chk("hi_step_break", 32'(state), 32'd4);
    chk("hi_retired", retired, 32'd7);
    run_req = 1'b0;
    tick();
    chk("hi_drop_halt", 32'(state), 32'd1);
    tick(6);
    inst = 32'h20080005;
    pc = 32'h18;
    run_req = 1'b1;
    tick();
    chk("r6_state", 32'(state), 32'd3);
    tick(2);
    chk("r6_retired", retired, 32'd9);
    step_btn = 1'b1;
    tick(2);
    chk("r6_retired2", retired, 32'd11);
    reset = 1'b1;
    step_btn = 1'b0;
    run_req = 1'b0;
    tick();
    chk("r6_rst_state", 32'(state), 32'd0);
    chk("r6_rst_en", 32'(cpu_en), 32'd0);
    chk("r6_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("r6_rst_retired", retired, 32'd0);
    reset = 1'b0;
    tick(4);
    chk("r6_init_done", 32'(state), 32'd1);
    en_cnt = 0;
    tick(10);
    chk("r6_no_pulse_en", 32'(en_cnt), 32'd0);
    chk("r6_no_pulse_state", 32'(state), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
